// File: rtl/spi_slave_core_pkg.sv
// Shared types and constants for the SPI responder core.
package spi_slave_core_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } spiState_t;

  // Levels the pin synchronizers settle to while held in reset.
  localparam logic SCLK_RESET_LEVEL = 1'b0;
  localparam logic CS_RESET_LEVEL   = 1'b1;
  localparam logic MOSI_RESET_LEVEL = 1'b0;

  // Replicates the byte-wide fill pattern so any word length up to 32 can slice it.
  function automatic logic [31:0] replicateFill(input logic [7:0] fill);
    return {4{fill}};
  endfunction

endpackage

// File: rtl/spi_slave_core_in_sync.sv
// Pin synchronizer: two metastability flops, then a delay flop for edge detection.
module spi_slave_core_in_sync
  import spi_slave_core_pkg::*;
#(
  parameter logic RESET_VAL = MOSI_RESET_LEVEL
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // Bring the asynchronous pin into the clock domain and keep one older copy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_dly  <= RESET_VAL;
    end else if (i_clear) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_dly  <= RESET_VAL;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_dly;
  assign o_fall  = ~r_sync & r_dly;

endmodule

// File: rtl/spi_slave_core.sv
// SPI responder: oversampled pins, CPOL/CPHA edge mapping, shift registers and TX holding register.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int         DW        = 8,
  parameter bit         LSB_FIRST = 1'b0,
  parameter logic [7:0] TX_FILL   = 8'hFF
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          CPOL,
  input  logic          CPHA,
  input  logic          sclk_i,
  input  logic          cs_n_i,
  input  logic          mosi_i,
  output logic          miso_o,
  output logic          miso_oe,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          tx_underrun,
  output logic          busy
);

  localparam int             CW        = $clog2(DW);
  localparam logic [31:0]    FILL32    = replicateFill(TX_FILL);
  localparam logic [DW-1:0]  FILL_WORD = FILL32[DW-1:0];
  localparam logic [CW-1:0]  LAST_BIT  = CW'(DW - 1);

  logic w_clear;
  logic w_sclkLevel, w_sclkRise, w_sclkFall;
  logic w_csLevel, w_csRise, w_csFall;
  logic w_mosi, w_mosiRise, w_mosiFall;
  logic w_leadEdge, w_trailEdge, w_sampleEdge, w_shiftEdge;
  logic w_unusedSync;

  spiState_t r_state;
  spiState_t w_nextState;
  logic      w_doLoad;
  logic      w_doShift;
  logic      w_doSample;

  logic [CW-1:0] r_bitCnt;
  logic [DW-1:0] r_rxShift;
  logic [DW-1:0] r_rxData;
  logic          r_rxValid;
  logic [DW-1:0] r_txShift;
  logic          r_miso;
  logic          r_txUnderrun;
  logic [DW-1:0] r_txBuf;
  logic          r_txReady;

  logic [DW-1:0] w_loadWord;
  logic          w_loadBit;
  logic [DW-1:0] w_txRot;
  logic          w_shiftBit;
  logic [DW-1:0] w_rxNext;

  assign w_clear = ~enable;

  spi_slave_core_in_sync #(.RESET_VAL(SCLK_RESET_LEVEL)) u_syncSclk (
    .i_clk(sysclk), .i_rst_n(rst_n), .i_clear(w_clear), .i_pin(sclk_i),
    .o_level(w_sclkLevel), .o_rise(w_sclkRise), .o_fall(w_sclkFall)
  );

  spi_slave_core_in_sync #(.RESET_VAL(CS_RESET_LEVEL)) u_syncCs (
    .i_clk(sysclk), .i_rst_n(rst_n), .i_clear(w_clear), .i_pin(cs_n_i),
    .o_level(w_csLevel), .o_rise(w_csRise), .o_fall(w_csFall)
  );

  spi_slave_core_in_sync #(.RESET_VAL(MOSI_RESET_LEVEL)) u_syncMosi (
    .i_clk(sysclk), .i_rst_n(rst_n), .i_clear(w_clear), .i_pin(mosi_i),
    .o_level(w_mosi), .o_rise(w_mosiRise), .o_fall(w_mosiFall)
  );

  // Synchronizer taps and shift-register bits that the datapath does not read.
  assign w_unusedSync = ^{w_sclkLevel, w_csLevel, w_mosiRise, w_mosiFall, r_rxShift};

  // Leading edge leaves the idle level; CPHA picks which edge samples and which shifts.
  assign w_leadEdge   = CPOL ? w_sclkFall : w_sclkRise;
  assign w_trailEdge  = CPOL ? w_sclkRise : w_sclkFall;
  assign w_sampleEdge = CPHA ? w_trailEdge : w_leadEdge;
  assign w_shiftEdge  = CPHA ? w_leadEdge : w_trailEdge;

  // An empty holding register means the load sends the fill pattern instead.
  assign w_loadWord = r_txReady ? FILL_WORD : r_txBuf;
  assign w_loadBit  = LSB_FIRST ? w_loadWord[0] : w_loadWord[DW-1];
  assign w_txRot    = LSB_FIRST ? {r_txShift[0], r_txShift[DW-1:1]}
                                : {r_txShift[DW-2:0], r_txShift[DW-1]};
  assign w_shiftBit = LSB_FIRST ? r_txShift[1] : r_txShift[DW-2];
  assign w_rxNext   = LSB_FIRST ? {w_mosi, r_rxShift[DW-1:1]}
                                : {r_rxShift[DW-2:0], w_mosi};

  // State register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (w_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus the per-cycle load / shift / sample decisions.
  always_comb begin
    w_nextState = r_state;
    w_doLoad    = 1'b0;
    w_doShift   = 1'b0;
    w_doSample  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_csFall) begin
          w_nextState = S_ACTIVE;
          w_doLoad    = ~CPHA;
        end
      end
      S_ACTIVE: begin
        if (w_csRise) begin
          w_nextState = S_IDLE;
        end else begin
          w_doSample = w_sampleEdge;
          if (w_shiftEdge) begin
            if (r_bitCnt == {CW{1'b0}}) begin
              w_doLoad = 1'b1;
            end else begin
              w_doShift = 1'b1;
            end
          end
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Bit counter, receive assembly, transmit shifting and the registered MISO bit.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitCnt     <= '0;
      r_rxShift    <= '0;
      r_rxData     <= '0;
      r_rxValid    <= 1'b0;
      r_txShift    <= '0;
      r_miso       <= 1'b0;
      r_txUnderrun <= 1'b0;
    end else if (w_clear) begin
      r_bitCnt     <= '0;
      r_rxShift    <= '0;
      r_rxData     <= '0;
      r_rxValid    <= 1'b0;
      r_txShift    <= '0;
      r_miso       <= 1'b0;
      r_txUnderrun <= 1'b0;
    end else begin
      r_rxValid    <= 1'b0;
      r_txUnderrun <= 1'b0;
      if (w_nextState == S_IDLE) begin
        r_bitCnt <= '0;
        r_miso   <= 1'b0;
      end else begin
        if (w_doSample) begin
          r_rxShift <= w_rxNext;
          if (r_bitCnt == LAST_BIT) begin
            r_rxData  <= w_rxNext;
            r_rxValid <= 1'b1;
            r_bitCnt  <= '0;
          end else begin
            r_bitCnt <= r_bitCnt + CW'(1);
          end
        end
        if (w_doLoad) begin
          r_txShift    <= w_loadWord;
          r_miso       <= w_loadBit;
          r_txUnderrun <= r_txReady;
        end else if (w_doShift) begin
          r_txShift <= w_txRot;
          r_miso    <= w_shiftBit;
        end
      end
    end
  end

  // TX holding register; only a true reset discards the buffered word itself.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_txBuf   <= '0;
      r_txReady <= 1'b1;
    end else if (w_clear) begin
      r_txReady <= 1'b1;
    end else if (tx_valid && r_txReady) begin
      r_txBuf   <= tx_data;
      r_txReady <= 1'b0;
    end else if (w_doLoad && !r_txReady) begin
      r_txReady <= 1'b1;
    end
  end

  assign busy        = (r_state == S_ACTIVE);
  assign miso_oe     = busy;
  assign miso_o      = r_miso & busy;
  assign tx_ready    = r_txReady;
  assign rx_data     = r_rxData;
  assign rx_valid    = r_rxValid;
  assign tx_underrun = r_txUnderrun;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: bit-banged SPI master plus a word-level holding-register model.
module tb_spi_slave_core;

  localparam int DW   = 8;
  localparam int HALF = 4;

  logic          sysclk = 1'b0;
  logic          rst_n, enable, CPOL, CPHA, sclk_i, cs_n_i, mosi_i;
  logic          miso_o, miso_oe, tx_valid, tx_ready, rx_valid, tx_underrun, busy;
  logic [DW-1:0] tx_data, rx_data;

  int compared   = 0;
  int mismatched = 0;

  // Model of the holding register and of each word the responder should shift out.
  bit          modelHave;
  logic [7:0]  modelWord;
  logic [7:0]  expLoadQ[$];
  int          expUnderruns;
  int          seenUnderruns;
  logic [7:0]  rxQ[$];
  logic [7:0]  lastRx;
  bit          autoRefill;
  bit          refillReq;

  spi_slave_core dut (
    .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .CPOL(CPOL), .CPHA(CPHA),
    .sclk_i(sclk_i), .cs_n_i(cs_n_i), .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
  );

  // Free-running system clock.
  always #5 sysclk = ~sysclk;

  // Hard stop in case something stalls beyond any sane run length.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic bitOf(input logic [7:0] word, input int idx);
    return word[7 - idx];
  endfunction

  task automatic modelPush(input logic [7:0] word);
    modelHave = 1'b1;
    modelWord = word;
  endtask

  task automatic modelLoad();
    if (modelHave) begin
      expLoadQ.push_back(modelWord);
      modelHave = 1'b0;
    end else begin
      expLoadQ.push_back(8'hFF);
      expUnderruns++;
    end
  endtask

  // One sysclk: record handshakes and strobes, and refill the holding register after each received word.
  task automatic tick();
    bit accept;
    accept = tx_valid && tx_ready;
    @(posedge sysclk);
    #1;
    if (accept) begin
      modelPush(tx_data);
      tx_valid = 1'b0;
    end
    if (rx_valid) begin
      rxQ.push_back(rx_data);
      if (autoRefill) refillReq = 1'b1;
    end
    if (tx_underrun) seenUnderruns++;
    if (refillReq && !tx_valid && !modelHave) begin
      tx_data   = 8'($urandom);
      tx_valid  = 1'b1;
      refillReq = 1'b0;
    end
  endtask

  task automatic preloadTx(input logic [7:0] word);
    if (!modelHave) begin
      tx_data  = word;
      tx_valid = 1'b1;
      for (int i = 0; i < 8 && tx_valid; i++) tick();
      checkOutput("preload accepted", 32'(tx_valid), 32'(0));
      tx_valid = 1'b0;
    end
  endtask

  // One chip-select frame of nWords words; abortAfter>0 raises cs_n after that many bits.
  task automatic applyStimulus(input logic cpol, input logic cpha, input int nWords,
                               input logic [7:0] words [3], input int abortAfter, input bit refill);
    logic [7:0] misoWord;
    logic [7:0] expWord;
    int         bitsToRun;
    int         expRx;
    CPOL   = cpol;
    CPHA   = cpha;
    sclk_i = cpol;
    mosi_i = 1'b0;
    repeat (6) tick();
    expLoadQ.delete();
    rxQ.delete();
    seenUnderruns = 0;
    expUnderruns  = 0;
    autoRefill    = refill;
    if (!cpha) begin
      modelLoad();
      mosi_i = bitOf(words[0], 0);
    end
    cs_n_i = 1'b0;
    repeat (8) tick();
    bitsToRun = (abortAfter > 0) ? abortAfter : DW;
    for (int w = 0; w < nWords; w++) begin
      misoWord = '0;
      for (int b = 0; b < bitsToRun; b++) begin
        if (!cpha) begin
          misoWord = {misoWord[6:0], miso_o};
          sclk_i = ~cpol;
          repeat (HALF) tick();
          sclk_i = cpol;
          if (b == DW - 1) begin
            modelLoad();
            if (w + 1 < nWords) mosi_i = bitOf(words[w + 1], 0);
          end else begin
            mosi_i = bitOf(words[w], b + 1);
          end
          repeat (HALF) tick();
        end else begin
          sclk_i = ~cpol;
          if (b == 0) modelLoad();
          mosi_i = bitOf(words[w], b);
          repeat (HALF) tick();
          misoWord = {misoWord[6:0], miso_o};
          sclk_i = cpol;
          repeat (HALF) tick();
        end
      end
      if (abortAfter == 0) begin
        expWord = (expLoadQ.size() > 0) ? expLoadQ.pop_front() : 8'hxx;
        checkOutput($sformatf("miso mode%0d%0d word%0d", cpol, cpha, w), 32'(misoWord), 32'(expWord));
      end
    end
    repeat (2) tick();
    autoRefill = 1'b0;
    refillReq  = 1'b0;
    cs_n_i     = 1'b1;
    repeat (4) tick();
    checkOutput("miso_oe after cs_n high", 32'(miso_oe), 32'(0));
    checkOutput("busy after cs_n high", 32'(busy), 32'(0));
    repeat (4) tick();
    for (int i = 0; i < 10 && tx_valid; i++) tick();
    checkOutput("tx handshake drained", 32'(tx_valid), 32'(0));
    tx_valid = 1'b0;
    expRx = (abortAfter > 0) ? 0 : nWords;
    checkOutput("rx_valid count", 32'(rxQ.size()), 32'(expRx));
    for (int i = 0; i < rxQ.size() && i < nWords; i++) begin
      checkOutput($sformatf("rx word%0d", i), 32'(rxQ[i]), 32'(words[i]));
    end
    if (expRx > 0) lastRx = words[nWords - 1];
    checkOutput("rx_data held", 32'(rx_data), 32'(lastRx));
    checkOutput("underrun count", 32'(seenUnderruns), 32'(expUnderruns));
    checkOutput("tx_ready", 32'(tx_ready), 32'(!modelHave));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " miso_o"}, 32'(miso_o), 32'(0));
    checkOutput({tag, " miso_oe"}, 32'(miso_oe), 32'(0));
    checkOutput({tag, " tx_ready"}, 32'(tx_ready), 32'(1));
    checkOutput({tag, " rx_data"}, 32'(rx_data), 32'(0));
    checkOutput({tag, " rx_valid"}, 32'(rx_valid), 32'(0));
    checkOutput({tag, " tx_underrun"}, 32'(tx_underrun), 32'(0));
    checkOutput({tag, " busy"}, 32'(busy), 32'(0));
  endtask

  // Directed scenarios followed by randomized frames.
  initial begin
    logic [7:0] w3 [3];
    logic cpol, cpha;
    int   nWords, abortAfter;
    bit   refill;

    rst_n = 1'b1; enable = 1'b1; CPOL = 1'b0; CPHA = 1'b0;
    sclk_i = 1'b0; cs_n_i = 1'b1; mosi_i = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    modelHave = 1'b0; modelWord = '0; lastRx = '0;
    autoRefill = 1'b0; refillReq = 1'b0;
    expUnderruns = 0; seenUnderruns = 0;

    #1 rst_n = 1'b0;
    #2;
    checkResetOutputs("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Mode 0, A5 preloaded, master sends 3C.
    preloadTx(8'hA5);
    w3 = '{8'h3C, 8'h00, 8'h00};
    applyStimulus(1'b0, 1'b0, 1, w3, 0, 1'b0);
    checkOutput("t1 rx_data", 32'(rx_data), 32'h3C);

    // All four modes, two words per frame.
    for (int m = 0; m < 4; m++) begin
      preloadTx(8'h81);
      w3 = '{8'h81, 8'h7E, 8'h00};
      applyStimulus(m[1], m[0], 2, w3, 0, 1'b1);
    end

    // Back-to-back words under one chip select with refills.
    preloadTx(8'($urandom));
    w3 = '{8'($urandom), 8'($urandom), 8'($urandom)};
    applyStimulus(1'b0, 1'b0, 3, w3, 0, 1'b1);
    checkOutput("t3 no underrun", 32'(seenUnderruns), 32'(0));

    // Underrun with an empty holding register.
    w3 = '{8'h5C, 8'h00, 8'h00};
    applyStimulus(1'b0, 1'b1, 1, w3, 0, 1'b0);
    checkOutput("t4 single underrun", 32'(seenUnderruns), 32'(1));

    // Abort after five SCK, then a full word.
    preloadTx(8'($urandom));
    w3 = '{8'hE7, 8'h00, 8'h00};
    applyStimulus(1'b0, 1'b0, 1, w3, 5, 1'b0);
    preloadTx(8'($urandom));
    w3 = '{8'h4B, 8'h00, 8'h00};
    applyStimulus(1'b0, 1'b0, 1, w3, 0, 1'b0);

    // Asynchronous reset in the middle of a word.
    preloadTx(8'hA5);
    CPOL = 1'b0; CPHA = 1'b0; sclk_i = 1'b0;
    repeat (4) tick();
    modelLoad();
    mosi_i = bitOf(8'h96, 0);
    cs_n_i = 1'b0;
    repeat (8) tick();
    for (int b = 0; b < 3; b++) begin
      sclk_i = 1'b1;
      repeat (HALF) tick();
      sclk_i = 1'b0;
      mosi_i = bitOf(8'h96, b + 1);
      repeat (HALF) tick();
    end
    sclk_i = 1'b1;
    repeat (2) tick();
    checkOutput("busy before reset", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid-word reset");
    sclk_i = 1'b0;
    cs_n_i = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    modelHave = 1'b0;
    lastRx = '0;
    expLoadQ.delete();
    repeat (3) tick();
    preloadTx(8'h5A);
    w3 = '{8'hC3, 8'h00, 8'h00};
    applyStimulus(1'b0, 1'b0, 1, w3, 0, 1'b0);

    // Randomized frames across modes, lengths, preload and refill choices.
    for (int r = 0; r < 12; r++) begin
      cpol   = 1'($urandom_range(0, 1));
      cpha   = 1'($urandom_range(0, 1));
      refill = 1'($urandom_range(0, 1));
      nWords = $urandom_range(1, 3);
      abortAfter = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      if (abortAfter > 0) nWords = 1;
      w3 = '{8'($urandom), 8'($urandom), 8'($urandom)};
      if ($urandom_range(0, 1) == 1) preloadTx(8'($urandom));
      applyStimulus(cpol, cpha, nWords, w3, abortAfter, refill);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
